// File: rtl/alu_acc_16.sv
// rtl/alu_acc_16.sv - 16-bit accumulator ALU with iterative shift-add multiply
// Optional signed-overflow flag on v_out when MYCPU_ALU_OVF_EN is defined.

module alu_acc_16 #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] acc_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             z_out,
    output logic             n_out,
    output logic             c_out,
    output logic             v_out
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic               z_q;
    logic               n_q;
    logic               c_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [2*WIDTH-1:0] prod_next;

    assign sum_ext  = {1'b0, acc_q} + {1'b0, d_in};
    assign diff_ext = {1'b0, acc_q} - {1'b0, d_in};

    // One shift-add step: multiplier LSB selects whether the shifted multiplicand accumulates.
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_in)
            OP_LOAD: alu_res = d_in;
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
            end
            OP_AND:  alu_res = acc_q & d_in;
            OP_OR:   alu_res = acc_q | d_in;
            OP_XOR:  alu_res = acc_q ^ d_in;
            OP_CLR:  alu_res = '0;
            default: alu_res = acc_q;
        endcase
    end

`ifdef MYCPU_ALU_OVF_EN
    logic v_q;
    logic alu_v;

    always_comb begin
        alu_v = 1'b0;
        if (op_in == OP_ADD) begin
            alu_v = (acc_q[WIDTH-1] == d_in[WIDTH-1]) &&
                    (alu_res[WIDTH-1] != acc_q[WIDTH-1]);
        end else if (op_in == OP_SUB) begin
            alu_v = (acc_q[WIDTH-1] != d_in[WIDTH-1]) &&
                    (alu_res[WIDTH-1] != acc_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else if (state_q == S_IDLE && start_in && op_in != OP_MUL) begin
            v_q <= alu_v;
        end else if (state_q == S_MUL && cnt_q == CNT_LAST) begin
            v_q <= 1'b0;
        end
    end

    assign v_out = v_q;
`else
    assign v_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            z_q      <= 1'b1;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        if (op_in == OP_MUL) begin
                            mcand_q  <= {{WIDTH{1'b0}}, acc_q};
                            mplier_q <= d_in;
                            prod_q   <= '0;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= S_MUL;
                        end else begin
                            acc_q  <= alu_res;
                            z_q    <= (alu_res == '0);
                            n_q    <= alu_res[WIDTH-1];
                            c_q    <= alu_c;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    prod_q   <= prod_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        acc_q   <= prod_next[WIDTH-1:0];
                        z_q     <= (prod_next[WIDTH-1:0] == '0);
                        n_q     <= prod_next[WIDTH-1];
                        c_q     <= |prod_next[2*WIDTH-1:WIDTH];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign acc_out  = acc_q;
    assign busy_out = busy_q;
    assign done_out = done_q;
    assign z_out    = z_q;
    assign n_out    = n_q;
    assign c_out    = c_q;

endmodule
